// File: rtl/kbd_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_fifo_ctrl
// Description : Keyboard receive FIFO between the PS/2 decoder and the CPU
//               bus. Captures one ASCII byte per key press, raises an IRQ,
//               and exposes a pop-on-read data register and a status
//               register. Optional macro KBD_FIFO_DROP_CNT_EN adds a
//               saturating dropped-byte counter in status bits [31:24].
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo_ctrl #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_3000,
    parameter logic [3:0]  IRQ_ID    = 4'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_pressed,
    input  logic [7:0]  ascii,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        bus_hit,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack,
    output logic [7:0]  fifo_count
);

    localparam int unsigned   PW        = $clog2(DEPTH);
    localparam int unsigned   CW        = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [63:0]   STAT_ADDR = BASE_ADDR + 64'd4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_t;

    logic          key_q;
    logic          rd_en_q;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    irq_state_t    irq_state;

    logic          push_req;
    logic          rd_edge;
    logic          data_sel;
    logic          stat_sel;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_evt;
    logic [7:0]    head;
    logic [7:0]    drop_field;
    logic [63:0]   status_word;

    // Only the rising edge of the decoder level and of the read strobe act,
    // so a held key or a long CPU read cycle produces a single event.
    assign push_req = key_pressed & ~key_q & (ascii != 8'd0);
    assign rd_edge  = bus_read_enable & ~rd_en_q;
    assign data_sel = rd_edge & (bus_address == BASE_ADDR);
    assign stat_sel = rd_edge & (bus_address == STAT_ADDR);

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = data_sel & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_evt  = push_req & full & ~pop;
    assign head     = mem[rd_ptr];

    assign status_word = {32'd0, drop_field, 8'd0, 8'(count),
                          5'd0, overflow, full, ~empty};

    assign fifo_count = 8'(count);

    // Edge-detect history for the key level and the read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            key_q   <= key_pressed;
            rd_en_q <= bus_read_enable;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ascii;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats the clear-on-status-read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_evt) begin
            overflow <= 1'b1;
        end else if (stat_sel) begin
            overflow <= 1'b0;
        end
    end

`ifdef KBD_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating dropped-byte counter, cleared by a status read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'd0;
        end else if (ovf_evt) begin
            if (stat_sel) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (stat_sel) begin
            drop_cnt <= 8'd0;
        end
    end

    assign drop_field = drop_cnt;
`else
    assign drop_field = 8'd0;
`endif

    // Registered bus response: updated on a read edge, held while the strobe
    // stays high, cleared once the strobe drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_read_data <= 64'd0;
            bus_hit       <= 1'b0;
        end else if (!bus_read_enable) begin
            bus_read_data <= 64'd0;
            bus_hit       <= 1'b0;
        end else if (rd_edge) begin
            if (data_sel) begin
                bus_read_data <= empty ? 64'd0 : {56'd0, head};
                bus_hit       <= 1'b1;
            end else if (stat_sel) begin
                bus_read_data <= status_word;
                bus_hit       <= 1'b1;
            end else begin
                bus_read_data <= 64'd0;
                bus_hit       <= 1'b0;
            end
        end
    end

    // Interrupt request FSM; only an ack clears it, and a push arriving with
    // the ack keeps the request pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_state        <= IDLE;
            interrupt_vector <= 4'd0;
        end else begin
            case (irq_state)
                IDLE: begin
                    if (push_ok) begin
                        irq_state        <= PEND;
                        interrupt_vector <= IRQ_ID;
                    end
                end
                PEND: begin
                    if (interrupt_ack && !push_ok) begin
                        irq_state        <= IDLE;
                        interrupt_vector <= 4'd0;
                    end
                end
                default: begin
                    irq_state        <= IDLE;
                    interrupt_vector <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/kbd_fifo_ctrl.md
Name: kbd_fifo_ctrl

Overview:
- Keyboard receive buffer between the PS/2 decoder and the system bus / interrupt controller.
- Captures one ASCII byte per key-press edge into a FIFO and raises a keyboard interrupt request.
- Exposes a pop-on-read data register and a status register on the bus.
- Replaces the direct "read ascii at Key_base" path so keystrokes are not lost while the slow CPU clock runs.

Parameters:
DEPTH, 16, FIFO entries; power of 2, range 2..128
BASE_ADDR, 64'h0000_0000_0000_3000, data register address; status register is BASE_ADDR+4
IRQ_ID, 4'd1, value driven on interrupt_vector while a request is pending

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous active-low reset
key_pressed  in  1  decoder key-pressed level
ascii  in  8  decoder ASCII code, valid while key_pressed high
bus_address  in  64  CPU bus address
bus_read_enable  in  1  CPU bus read strobe (level; may stay high for many clk cycles)
bus_read_data  out  64  registered read data
bus_hit  out  1  registered; high when the current read targets this block
interrupt_vector  out  4  IRQ_ID while pending, else 0
interrupt_ack  in  1  CPU acknowledge
fifo_count  out  8  current occupancy, zero-extended, for debug LEDs

Behaviour:
- Reset (async, reset_n low): FIFO empty, pointers 0, overflow flag 0, irq pending 0, bus_read_data 0, bus_hit 0, interrupt_vector 0. Any in-flight operation is discarded.
- Push event:
  - push = key_pressed & ~key_pressed_q & (ascii != 0), with key_pressed_q the 1-cycle delayed key_pressed.
  - One push per press, no matter how long the key is held.
- Read-edge detection: rd_edge = bus_read_enable & ~rd_en_q. Only rd_edge causes side effects, so a strobe held high pops exactly once.
- Data read (bus_address == BASE_ADDR, rd_edge):
  - Next cycle, bus_read_data = {56'd0, head byte} and bus_hit = 1.
  - FIFO pops if non-empty. If empty, returns 0 and nothing is popped.
- Status read (bus_address == BASE_ADDR+4, rd_edge):
  - Next cycle, bus_read_data = {48'd0, count[7:0], 5'd0, overflow, full, ~empty} and bus_hit = 1.
  - The overflow flag clears on this read, unless an overflow occurs in the same cycle; that overflow wins.
- While bus_read_enable stays high with no new edge, bus_read_data and bus_hit hold.
- When bus_read_enable is low, bus_read_data and bus_hit go to 0 on the next clk edge.
- Any other address: bus_read_data 0, bus_hit 0, no side effects.
- Read latency is 1 clk.
- Full and empty boundaries:
  - Push when full: byte dropped, overflow set, count unchanged.
  - Push and pop in the same cycle when full: both accepted, count stays DEPTH, pushed byte lands in the freed slot.
  - Push and pop in the same cycle when empty: the pop returns 0 and the push is accepted, so count ends at 1.
  - Push and pop otherwise: both occur, count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- IRQ state machine, two states, IDLE and PEND:
  - IDLE→PEND on an accepted push.
  - PEND→IDLE on interrupt_ack=1. An accepted push in the same cycle as the ack keeps PEND.
  - interrupt_vector = PEND ? IRQ_ID : 0, registered.
  - Ack while IDLE is ignored.
  - Draining the FIFO does not clear PEND; only ack does.
- fifo_count is combinational from count.

Optional Feature:
KBD_FIFO_DROP_CNT_EN
- Defined: adds an 8-bit saturating dropped-byte counter, increments per rejected push, stops at 255.
  - Reported in status bits [31:24].
  - Cleared to 0 on a status read (rd_edge); a drop in the same cycle makes it 1.
- Undefined: no counter; status bits [31:24] read 0.

Test Plan:
- Reset, then press 'a' (ascii 8'h61) once, held 100 cycles → count 1, interrupt_vector 1 after 1 clk; data read → bus_read_data 64'h61, count 0.
- Read strobe held high for 50 cycles on BASE_ADDR with 3 bytes queued (0x31,0x32,0x33) → exactly one pop, data 0x31 held all 50 cycles, count 2; strobe low → data 0 next cycle.
- Push DEPTH+2 bytes, then status read → {count=16, overflow=1, full=1, nonempty=1} = 64'h1007; second status read → 64'h1003; with KBD_FIFO_DROP_CNT_EN, bits[31:24]=2 on the first read, 0 on the second.
- Full FIFO, push 0x7A in the same cycle as a data-read edge → oldest byte returned, count stays 16; after 16 further reads the last byte returned is 0x7A.
- interrupt_ack asserted in the same cycle as a new push while PEND → interrupt_vector stays 1; ack alone next → 0 after 1 clk.
- reset_n asserted low mid-stream with 5 bytes queued and a pending IRQ → all outputs 0 immediately (async); data read afterwards returns 0.
